// File: rtl/mux_sel_arbiter.sv
// Purpose : round-robin, packet-locked arbiter between two valid/ready sources
//           feeding a single-stage output register plus the mux select (sel).
// Latency : 1 cycle (beat accepted at edge N is on out_*/sel in cycle N+1).
// Backpressure: the output register reloads only when empty or being drained
//           (can_load); source readies follow can_load, so out_ready=0 with a
//           full register stalls both sources.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   a_valid/a_data/a_last  source A beat, a_ready returned combinationally
//   b_valid/b_data/b_last  source B beat, b_ready returned combinationally
//   out_valid/out_data/out_last/out_ready  registered downstream beat
//   sel                   source of the registered beat (0=A, 1=B)
//   busy                  a multi-beat packet is in progress (locked)
module mux_sel_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,

    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,

    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,

    output logic              sel,
    output logic              busy
);

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic              prio_q,      prio_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic              sel_q,       sel_d;
    logic              busy_q,      busy_d;

    // ------------------------------------------------------------------
    // Arbitration / handshake helpers
    // ------------------------------------------------------------------
    logic              grant_vld;
    logic              grant_src;
    logic              src_valid;
    logic              src_last;
    logic [DATA_W-1:0] src_data;
    logic              can_load;
    logic              fire;

    // Register may take a new beat when empty or when its current beat is
    // leaving this same cycle (bubble-free pass-through).
    assign can_load = !out_valid_q || out_ready;

    // Grant selection. While locked the owner keeps the grant even if its
    // valid drops, so the other source simply waits out the gap.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_A;
        unique case (state_q)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant_vld = 1'b1;
                    grant_src = prio_q;
                end else if (a_valid) begin
                    grant_vld = 1'b1;
                    grant_src = SRC_A;
                end else if (b_valid) begin
                    grant_vld = 1'b1;
                    grant_src = SRC_B;
                end
            end
            LOCK_A: begin
                grant_vld = 1'b1;
                grant_src = SRC_A;
            end
            LOCK_B: begin
                grant_vld = 1'b1;
                grant_src = SRC_B;
            end
            default: begin
                grant_vld = 1'b0;
                grant_src = SRC_A;
            end
        endcase
    end

    // Source-side mux for the granted beat.
    always_comb begin
        src_valid = a_valid;
        src_last  = a_last;
        src_data  = a_data;
        if (grant_src == SRC_B) begin
            src_valid = b_valid;
            src_last  = b_last;
            src_data  = b_data;
        end
    end

    assign fire = !rst && grant_vld && can_load && src_valid;

    // ------------------------------------------------------------------
    // FSM process 1: state register (plus datapath/prio flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= SRC_A;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sel_q       <= SRC_A;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (fire) begin
            unique case (state_q)
                IDLE: begin
                    // A single-beat packet never locks.
                    if (!src_last) begin
                        state_d = (grant_src == SRC_B) ? LOCK_B : LOCK_A;
                    end
                end
                LOCK_A, LOCK_B: begin
                    if (src_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Round-robin: the source just finished gets lowest priority.
            if (src_last) begin
                prio_d = ~grant_src;
            end
        end
        // busy mirrors the registered state.
        busy_d = (state_d != IDLE);
    end

    // Output register next values.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sel_d       = sel_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = src_data;
            out_last_d  = src_last;
            sel_d       = grant_src;
        end else if (out_ready) begin
            // Drained with nothing to replace it; payload/sel hold.
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Readies are forced low while reset is asserted so no beat is
        // consumed upstream that the register would then discard.
        a_ready   = !rst && can_load && grant_vld && (grant_src == SRC_A);
        b_ready   = !rst && can_load && grant_vld && (grant_src == SRC_B);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_last  = out_last_q;
        sel       = sel_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Purpose : scoreboard bench for mux_sel_arbiter with directed packet vectors.
// Latency : expects each accepted beat on out_* one cycle after acceptance.
// Backpressure: drives out_ready directly, including multi-cycle stalls.
module tb_mux_sel_arbiter;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;    // idle cycles before this beat is presented
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       sel;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       a_valid, a_last, a_ready;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_ready;
    logic [7:0] b_data;
    logic       out_valid, out_last, out_ready;
    logic [7:0] out_data;
    logic       sel, busy;

    beat_t a_q[$];
    beat_t b_q[$];
    exp_t  exp_q[$];
    int    pop_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int b_early = 0;

    mux_sel_arbiter #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d, input logic l, input int g);
        beat_t b;
        b.data = d; b.last = l; b.gap = g;
        a_q.push_back(b);
    endtask

    task automatic push_b(input logic [7:0] d, input logic l, input int g);
        beat_t b;
        b.data = d; b.last = l; b.gap = g;
        b_q.push_back(b);
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l, input logic s, input logic bz);
        exp_t e;
        e.data = d; e.last = l; e.sel = s; e.busy = bz;
        exp_q.push_back(e);
    endtask

    // Source A driver: fire sampled at negedge, next beat presented after posedge.
    initial begin
        bit a_fire;
        int a_gapcnt;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0; a_gapcnt = 0;
        forever begin
            @(negedge clk);
            a_fire = a_valid && a_ready && !rst;
            @(posedge clk);
            #1;
            if (a_fire && a_q.size() > 0) begin
                void'(a_q.pop_front());
                a_gapcnt = 0;
            end
            if (rst || a_q.size() == 0) begin
                a_valid  = 1'b0;
                a_gapcnt = rst ? 0 : a_gapcnt;
            end else if (a_gapcnt < a_q[0].gap) begin
                a_valid = 1'b0;
                a_gapcnt++;
            end else begin
                a_valid = 1'b1;
                a_data  = a_q[0].data;
                a_last  = a_q[0].last;
            end
        end
    end

    // Source B driver.
    initial begin
        bit b_fire;
        int b_gapcnt;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_gapcnt = 0;
        forever begin
            @(negedge clk);
            b_fire = b_valid && b_ready && !rst;
            @(posedge clk);
            #1;
            if (b_fire && b_q.size() > 0) begin
                void'(b_q.pop_front());
                b_gapcnt = 0;
            end
            if (rst || b_q.size() == 0) begin
                b_valid  = 1'b0;
                b_gapcnt = rst ? 0 : b_gapcnt;
            end else if (b_gapcnt < b_q[0].gap) begin
                b_valid = 1'b0;
                b_gapcnt++;
            end else begin
                b_valid = 1'b1;
                b_data  = b_q[0].data;
                b_last  = b_q[0].last;
            end
        end
    end

    // Monitor: every downstream handshake pops and compares one expected beat.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data=%0h sel=%0b, required no beat", out_data, sel);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (out_data !== e.data || out_last !== e.last || sel !== e.sel || busy !== e.busy) begin
                    errors++;
                    $display("FAIL beat: got data=%0h last=%0b sel=%0b busy=%0b, required data=%0h last=%0b sel=%0b busy=%0b",
                             out_data, out_last, sel, busy, e.data, e.last, e.sel, e.busy);
                end
            end
        end
    end

    // Wait until all stimulus is consumed and all expected beats are seen.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0) && n < 300) begin
            @(negedge clk);
            if (b_ready && a_q.size() > 0) b_early++;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats outstanding, required 0", name, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_sel",       sel,       0);
        chk("rst_a_ready",   a_ready,   0);
        rst = 1'b0;

        // Single A packet moves prio to B.
        @(negedge clk);
        push_a(8'h33, 1'b1, 0);
        expect_beat(8'h33, 1'b1, 1'b0, 1'b0);
        wait_done("first");

        // Mid-packet reset with B locked and stalled.
        @(posedge clk); #2 out_ready = 1'b0;
        @(negedge clk);
        push_b(8'h81, 1'b0, 0);
        push_b(8'h82, 1'b0, 0);
        repeat (4) @(negedge clk);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data",  out_data,  8'h81);
        chk("stall_sel",       sel,       1);
        chk("stall_busy",      busy,      1);
        chk("stall_b_ready",   b_ready,   0);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data",  out_data,  0);
        chk("midrst_sel",       sel,       0);
        chk("midrst_busy",      busy,      0);
        chk("midrst_b_ready",   b_ready,   0);
        chk("midrst_a_ready",   a_ready,   0);
        a_q.delete();
        b_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;

        // After reset prio is A again, so A wins the first contention.
        @(negedge clk);
        push_a(8'h44, 1'b1, 0);
        push_b(8'h55, 1'b1, 0);
        expect_beat(8'h44, 1'b1, 1'b0, 1'b0);
        expect_beat(8'h55, 1'b1, 1'b1, 1'b0);
        wait_done("post_reset");

        // Contention with single-beat packets: strict alternation, 1 beat/cycle.
        @(negedge clk);
        pop_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            push_a(8'h11, 1'b1, 0);
            push_b(8'h22, 1'b1, 0);
            expect_beat(8'h11, 1'b1, 1'b0, 1'b0);
            expect_beat(8'h22, 1'b1, 1'b1, 1'b0);
        end
        wait_done("contention");
        chk("contention_pops", pop_cyc.size(), 6);
        if (pop_cyc.size() == 6) chk("contention_rate", pop_cyc[5] - pop_cyc[0], 5);

        // Packet lock: B waits for A's whole 3-beat packet.
        @(negedge clk);
        b_early = 0;
        push_a(8'h01, 1'b0, 0);
        push_a(8'h02, 1'b0, 0);
        push_a(8'h03, 1'b1, 0);
        push_b(8'hB0, 1'b1, 0);
        expect_beat(8'h01, 1'b0, 1'b0, 1'b1);
        expect_beat(8'h02, 1'b0, 1'b0, 1'b1);
        expect_beat(8'h03, 1'b1, 1'b0, 1'b0);
        expect_beat(8'hB0, 1'b1, 1'b1, 1'b0);
        wait_done("lock");
        chk("lock_b_ready_early", b_early, 0);

        // Backpressure mid-packet for 4 cycles (prio is A; B idle).
        @(negedge clk);
        push_a(8'hC1, 1'b0, 0);
        push_a(8'hC2, 1'b0, 0);
        push_a(8'hC3, 1'b0, 0);
        push_a(8'hC4, 1'b1, 0);
        expect_beat(8'hC1, 1'b0, 1'b0, 1'b1);
        expect_beat(8'hC2, 1'b0, 1'b0, 1'b1);
        expect_beat(8'hC3, 1'b0, 1'b0, 1'b1);
        expect_beat(8'hC4, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (a_q.size() > 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_beat2", (n < 50), 1);
        @(posedge clk); #2 out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold", {out_data, out_last, sel, a_ready, out_valid}, {8'hC3, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        @(posedge clk); #2 out_ready = 1'b1;
        wait_done("backpressure");

        // Lock hold across a 3-cycle A gap; prio is B, so A starts alone.
        @(negedge clk);
        b_early = 0;
        push_a(8'hD1, 1'b0, 0);
        push_a(8'hD2, 1'b0, 3);
        push_a(8'hD3, 1'b1, 0);
        push_b(8'hE0, 1'b1, 1);
        expect_beat(8'hD1, 1'b0, 1'b0, 1'b1);
        expect_beat(8'hD2, 1'b0, 1'b0, 1'b1);
        expect_beat(8'hD3, 1'b1, 1'b0, 1'b0);
        expect_beat(8'hE0, 1'b1, 1'b1, 1'b0);
        wait_done("gap");
        chk("gap_b_ready_early", b_early, 0);

        // Single-source B stream: accepted back to back despite prio toggling.
        @(negedge clk);
        pop_cyc.delete();
        push_b(8'h5A, 1'b1, 0);
        push_b(8'h5B, 1'b1, 0);
        expect_beat(8'h5A, 1'b1, 1'b1, 1'b0);
        expect_beat(8'h5B, 1'b1, 1'b1, 1'b0);
        wait_done("b_only");
        chk("b_only_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2) chk("b_only_rate", pop_cyc[1] - pop_cyc[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
